// File: rtl/sdes_pkg.sv
// S-DES tables, FSM state type and bit-permutation helpers shared by the decryptor.
// Vectors are MSB-first: the leftmost S-DES bit is the vector MSB.
package sdes_pkg;

    localparam int unsigned KEY_W = 10;
    localparam int unsigned BLK_W = 8;

    // Tables hold 1-based positions counted from the leftmost input bit.
    localparam int unsigned P10_T    [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int unsigned P8_T     [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
    localparam int unsigned IP_T     [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
    localparam int unsigned IP_INV_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
    localparam int unsigned EP_T     [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
    localparam int unsigned P4_T     [4]  = '{2, 4, 3, 1};

    localparam logic [1:0] S0_T [4][4] = '{'{2'd1, 2'd0, 2'd3, 2'd2},
                                           '{2'd3, 2'd2, 2'd1, 2'd0},
                                           '{2'd0, 2'd2, 2'd1, 2'd3},
                                           '{2'd3, 2'd1, 2'd3, 2'd2}};
    localparam logic [1:0] S1_T [4][4] = '{'{2'd0, 2'd1, 2'd2, 2'd3},
                                           '{2'd2, 2'd0, 2'd1, 2'd3},
                                           '{2'd3, 2'd0, 2'd1, 2'd0},
                                           '{2'd2, 2'd1, 2'd0, 2'd3}};

    typedef enum logic [1:0] {IDLE, R1, R2, DONE} state_e;

    typedef struct packed {
        logic [BLK_W-1:0] k1;
        logic [BLK_W-1:0] k2;
    } subkeys_t;

    function automatic logic [7:0] ip(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[3'(7 - j)] = b[3'(8 - IP_T[3'(j)])];
        return r;
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[3'(7 - j)] = b[3'(8 - IP_INV_T[3'(j)])];
        return r;
    endfunction

    function automatic logic [7:0] sw(input logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] b);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[3'(7 - j)] = b[2'(4 - EP_T[3'(j)])];
        return r;
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] b);
        logic [3:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) r[2'(3 - j)] = b[2'(4 - P4_T[2'(j)])];
        return r;
    endfunction

    function automatic logic [9:0] p10(input logic [9:0] k);
        logic [9:0] r;
        r = '0;
        for (int j = 0; j < 10; j++) r[4'(9 - j)] = k[4'(10 - P10_T[4'(j)])];
        return r;
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        logic [7:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[3'(7 - j)] = k[4'(10 - P8_T[3'(j)])];
        return r;
    endfunction

    // K1 after a 1-bit rotate of each half, K2 after a further 2-bit rotate.
    function automatic subkeys_t keygen(input logic [9:0] key);
        logic [9:0] p;
        logic [4:0] l1, r1, l2, r2;
        subkeys_t   ks;
        p     = p10(key);
        l1    = {p[8:5], p[9]};
        r1    = {p[3:0], p[4]};
        l2    = {l1[2:0], l1[4:3]};
        r2    = {r1[2:0], r1[4:3]};
        ks.k1 = p8({l1, r1});
        ks.k2 = p8({l2, r2});
        return ks;
    endfunction

endpackage

// File: rtl/sdes_fk.sv
// One S-DES Feistel round: (L ^ F(R, K)) | R.
module sdes_fk
    import sdes_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic [7:0] subkey_i,
    output logic [7:0] data_c_o
);

    logic [3:0] left, right;
    logic [7:0] mixed;
    logic [1:0] s0_out, s1_out;

    assign left   = data_i[7:4];
    assign right  = data_i[3:0];
    assign mixed  = ep(right) ^ subkey_i;
    // Row from outer bits, column from inner bits of each nibble.
    assign s0_out = S0_T[{mixed[7], mixed[4]}][{mixed[6], mixed[5]}];
    assign s1_out = S1_T[{mixed[3], mixed[0]}][{mixed[2], mixed[1]}];

    assign data_c_o = {left ^ p4({s0_out, s1_out}), right};

endmodule

// File: rtl/sdes_decrypt_seq.sv
// Round-serial S-DES decryptor with a persistent key register and valid/ready streaming.
module sdes_decrypt_seq
    import sdes_pkg::*;
#(
    parameter bit OUT_HOLD = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             key_load_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             key_ok_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [BLK_W-1:0] ciphertext_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [BLK_W-1:0] plaintext_o
);

    state_e           state_q, state_d;
    logic [BLK_W-1:0] k1_q, k1_d, k2_q, k2_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic [BLK_W-1:0] pt_q, pt_d;
    logic             key_ok_q, key_ok_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    subkeys_t         sched;
    logic [BLK_W-1:0] fk_in, fk_key, fk_out;

    assign sched = keygen(key_i);

    // Single round datapath: K2 on raw data in R1, K1 on swapped data in R2.
    assign fk_in  = (state_q == R2) ? sw(data_q) : data_q;
    assign fk_key = (state_q == R2) ? k1_q : k2_q;

    sdes_fk u_fk (
        .data_i   (fk_in),
        .subkey_i (fk_key),
        .data_c_o (fk_out)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            k1_q        <= '0;
            k2_q        <= '0;
            data_q      <= '0;
            pt_q        <= '0;
            key_ok_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k1_q        <= k1_d;
            k2_q        <= k2_d;
            data_q      <= data_d;
            pt_q        <= pt_d;
            key_ok_q    <= key_ok_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k1_d        = k1_q;
        k2_d        = k2_q;
        data_d      = data_q;
        pt_d        = pt_q;
        key_ok_d    = key_ok_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                // A key load wins the cycle; a pending block is taken on a later IDLE cycle.
                if (key_load_i) begin
                    k1_d     = sched.k1;
                    k2_d     = sched.k2;
                    key_ok_d = 1'b1;
                end else if (in_valid_i && in_ready_q) begin
                    data_d  = ip(ciphertext_i);
                    state_d = R1;
                end
            end
            R1: begin
                data_d  = fk_out;
                state_d = R2;
            end
            R2: begin
                pt_d        = ip_inv(fk_out);
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (!OUT_HOLD || out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = key_ok_d && (state_d == IDLE);
    end

    assign key_ok_o    = key_ok_q;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign plaintext_o = pt_q;

endmodule

// File: tb/tb_sdes_decrypt_seq.sv
// Self-checking bench: independent S-DES encrypt model feeds ciphertext, scoreboard checks plaintext.
module tb_sdes_decrypt_seq;
    import sdes_pkg::*;

    logic       clk = 1'b0;
    logic       rst_i, key_load_i, in_valid_i, out_ready_i;
    logic [9:0] key_i;
    logic [7:0] ciphertext_i;
    logic       key_ok_o, in_ready_o, out_valid_o;
    logic [7:0] plaintext_o;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;
    logic [9:0] cur_key;

    always #5 clk = ~clk;

    sdes_decrypt_seq #(.OUT_HOLD(1'b1)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .key_load_i   (key_load_i),
        .key_i        (key_i),
        .key_ok_o     (key_ok_o),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .ciphertext_i (ciphertext_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .plaintext_o  (plaintext_o)
    );

    // ---------------- reference S-DES model ----------------
    localparam logic [1:0] M_S0 [16] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                         2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
    localparam logic [1:0] M_S1 [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                         2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

    function automatic logic [7:0] m_p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [15:0] m_keys(input logic [9:0] k);
        logic [9:0] p;
        logic [4:0] l1, r1, l2, r2;
        p  = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
        l1 = {p[8:5], p[9]};
        r1 = {p[3:0], p[4]};
        l2 = {l1[2:0], l1[4:3]};
        r2 = {r1[2:0], r1[4:3]};
        return {m_p8({l1, r1}), m_p8({l2, r2})};
    endfunction

    function automatic logic [7:0] m_fk(input logic [7:0] d, input logic [7:0] k);
        logic [7:0] x;
        logic [1:0] a, b;
        logic [3:0] s;
        x = {d[0], d[3], d[2], d[1], d[2], d[1], d[0], d[3]} ^ k;
        a = M_S0[{x[7], x[4], x[6], x[5]}];
        b = M_S1[{x[3], x[0], x[2], x[1]}];
        s = {a, b};
        return {d[7:4] ^ {s[2], s[0], s[1], s[3]}, d[3:0]};
    endfunction

    function automatic logic [7:0] m_encrypt(input logic [7:0] pt, input logic [9:0] k);
        logic [15:0] ks;
        logic [7:0]  t;
        ks = m_keys(k);
        t  = {pt[6], pt[2], pt[5], pt[7], pt[4], pt[0], pt[3], pt[1]};
        t  = m_fk(t, ks[15:8]);
        t  = {t[3:0], t[7:4]};
        t  = m_fk(t, ks[7:0]);
        return {t[4], t[7], t[5], t[3], t[1], t[6], t[0], t[2]};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: plaintext %b produced with none expected", plaintext_o);
            end else begin
                mon_exp = sb.pop_front();
                if (plaintext_o !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_plaintext: got %b expected %b", plaintext_o, mon_exp);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; key_load_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        key_i = '0; ciphertext_i = '0;
        tick; tick;
        checks++;
        if ({key_ok_o, in_ready_o, out_valid_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {key_ok_o, in_ready_o, out_valid_o});
        end
        checks++;
        if (plaintext_o !== 8'h00 || dut.k1_q !== 8'h00 || dut.k2_q !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: pt %h k1 %h k2 %h expected 00", plaintext_o, dut.k1_q, dut.k2_q);
        end
        rst_i = 1'b0;
        tick;
    endtask

    task automatic test_no_key;
        in_valid_i   = 1'b1;
        ciphertext_i = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (in_ready_o !== 1'b0 || dut.state_q !== IDLE) begin
                errors++;
                $display("FAIL no_key_accept: in_ready %b state %0d expected 0 / IDLE", in_ready_o, dut.state_q);
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_key_load;
        cur_key    = 10'b1010000010;
        key_i      = cur_key;
        key_load_i = 1'b1;
        tick;
        key_load_i = 1'b0;
        checks++;
        if (key_ok_o !== 1'b1 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL key_load_flags: key_ok %b in_ready %b expected 1 1", key_ok_o, in_ready_o);
        end
        checks++;
        if (dut.k1_q !== 8'b10100100 || dut.k2_q !== 8'b01000011) begin
            errors++;
            $display("FAIL key_subkeys: k1 %b k2 %b expected 10100100 01000011", dut.k1_q, dut.k2_q);
        end
    endtask

    task automatic test_known_vector;
        out_ready_i  = 1'b1;
        ciphertext_i = 8'b00111000;
        in_valid_i   = 1'b1;
        sb.push_back(8'b10010111);
        tick;
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL kv_e0: out_valid %b in_ready %b expected 0 0", out_valid_o, in_ready_o);
        end
        tick;
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL kv_e1_out_valid: got %b expected 0", out_valid_o);
        end
        tick;
        checks++;
        if (out_valid_o !== 1'b1 || plaintext_o !== 8'b10010111) begin
            errors++;
            $display("FAIL kv_e2: out_valid %b pt %b expected 1 10010111", out_valid_o, plaintext_o);
        end
        tick;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || plaintext_o !== 8'b10010111) begin
            errors++;
            $display("FAIL kv_e3: out_valid %b in_ready %b pt %b expected 0 1 10010111",
                     out_valid_o, in_ready_o, plaintext_o);
        end
    endtask

    task automatic test_hold;
        logic seen;
        out_ready_i  = 1'b0;
        ciphertext_i = m_encrypt(8'h5C, cur_key);
        in_valid_i   = 1'b1;
        sb.push_back(8'h5C);
        tick;
        in_valid_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (out_valid_o) seen = 1'b1;
            else tick;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL hold_timeout: out_valid %b expected 1 within 10 cycles", out_valid_o);
        end
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (out_valid_o !== 1'b1 || plaintext_o !== 8'h5C || in_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: out_valid %b pt %h in_ready %b expected 1 5c 0",
                         out_valid_o, plaintext_o, in_ready_o);
            end
        end
        out_ready_i = 1'b1;
        tick;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: out_valid %b in_ready %b expected 0 1", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_random;
        logic [7:0] pt;
        logic       acc;
        logic       drained;
        for (int kk = 0; kk < 4; kk++) begin
            out_ready_i = 1'b1;
            drained = 1'b0;
            for (int i = 0; i < 20 && !drained; i++) begin
                if (sb.size() == 0 && in_ready_o) drained = 1'b1;
                else tick;
            end
            checks++;
            if (!drained) begin
                errors++;
                $display("FAIL rand_drain: pending %0d in_ready %b expected 0 1", sb.size(), in_ready_o);
            end
            cur_key    = 10'($urandom);
            key_i      = cur_key;
            key_load_i = 1'b1;
            tick;
            key_load_i = 1'b0;
            for (int b = 0; b < 250; b++) begin
                pt           = 8'($urandom);
                ciphertext_i = m_encrypt(pt, cur_key);
                in_valid_i   = 1'b1;
                acc          = 1'b0;
                for (int c = 0; c < 64; c++) begin
                    out_ready_i = ($urandom_range(0, 3) != 0);
                    if (in_ready_o) begin
                        sb.push_back(pt);
                        acc = 1'b1;
                    end
                    tick;
                    if (acc) break;
                end
                in_valid_i = 1'b0;
                if (!acc) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_accept_timeout: block %0d in_ready %b expected 1", b, in_ready_o);
                end
            end
        end
        out_ready_i = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rand_final_drain: pending %0d expected 0", sb.size());
        end
    endtask

    task automatic test_key_collision;
        logic [9:0]  nk;
        logic [15:0] ks;
        nk           = 10'b0111111101;
        ks           = m_keys(nk);
        key_i        = nk;
        key_load_i   = 1'b1;
        in_valid_i   = 1'b1;
        ciphertext_i = m_encrypt(8'hE1, nk);
        tick;
        key_load_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b1 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL coll_suppress: in_ready %b state %0d expected 1 / IDLE", in_ready_o, dut.state_q);
        end
        checks++;
        if (dut.k1_q !== ks[15:8] || dut.k2_q !== ks[7:0]) begin
            errors++;
            $display("FAIL coll_keys: k1 %b k2 %b expected %b %b", dut.k1_q, dut.k2_q, ks[15:8], ks[7:0]);
        end
        sb.push_back(8'hE1);
        tick;
        in_valid_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b0 || dut.state_q !== R1) begin
            errors++;
            $display("FAIL coll_accept: in_ready %b state %0d expected 0 / R1", in_ready_o, dut.state_q);
        end
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL coll_output: pending %0d expected 0", sb.size());
        end
        tick;
    endtask

    task automatic test_reset_r2;
        logic stray;
        out_ready_i  = 1'b1;
        ciphertext_i = 8'h3C;
        in_valid_i   = 1'b1;
        tick;
        in_valid_i = 1'b0;
        tick;
        checks++;
        if (dut.state_q !== R2) begin
            errors++;
            $display("FAIL rst_r2_setup: state %0d expected R2", dut.state_q);
        end
        rst_i = 1'b1;
        tick;
        checks++;
        if ({out_valid_o, key_ok_o, in_ready_o} !== 3'b000 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL rst_r2_flags: ov/kok/ir %b state %0d expected 000 / IDLE",
                     {out_valid_o, key_ok_o, in_ready_o}, dut.state_q);
        end
        rst_i = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL rst_r2_discard: out_valid %b in_ready %b expected 0 0 after reset",
                     out_valid_o, in_ready_o);
        end
    endtask

    initial begin
        test_reset;
        test_no_key;
        test_key_load;
        test_known_vector;
        test_hold;
        test_random;
        test_key_collision;
        test_reset_r2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: pending %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
